// File: rtl/tft_timing_gen.sv
// Purpose: RGB/TFT raster timing generator with pixel-request lead and built-in test patterns.
// Latency: every output is registered and reflects counter position (h,v) one clock later.
// Backpressure: none; the pixel source must return data exactly REQ_LEAD-1 clocks after pix_req.
module tft_timing_gen #(
  parameter int H_SYNC   = 128,
  parameter int H_BACK   = 88,
  parameter int H_VALID  = 800,
  parameter int H_FRONT  = 40,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_VALID  = 480,
  parameter int V_FRONT  = 10,
  parameter int CNT_W    = 12,
  parameter int DATA_W   = 16,
  parameter int REQ_LEAD = 1,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] pix_data,
  output logic              pix_req,
  output logic [CNT_W-1:0]  pix_x,
  output logic [CNT_W-1:0]  pix_y,
  output logic              hsync,
  output logic              vsync,
  output logic              tft_de,
  output logic [DATA_W-1:0] tft_rgb,
  output logic              frame_start,
  output logic              running
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;

  localparam logic [CNT_W-1:0] H_MAX  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_MAX  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] HA_BEG = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] HA_END = CNT_W'(H_SYNC + H_BACK + H_VALID);
  localparam logic [CNT_W-1:0] VA_BEG = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] VA_END = CNT_W'(V_SYNC + V_BACK + V_VALID);
  localparam logic [CNT_W-1:0] LEAD   = CNT_W'(REQ_LEAD);
  // One extra bit so h+REQ_LEAD near the end of a line cannot wrap into the window.
  localparam logic [CNT_W:0]   RQ_BEG = (CNT_W+1)'(H_SYNC + H_BACK);
  localparam logic [CNT_W:0]   RQ_END = (CNT_W+1)'(H_SYNC + H_BACK + H_VALID);
  localparam logic [CNT_W:0]   RQ_LD  = (CNT_W+1)'(REQ_LEAD);
  localparam logic             HS_ACT = (HS_POL != 0);
  localparam logic             VS_ACT = (VS_POL != 0);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_t;

  state_t            state_q, state_nx;
  logic [CNT_W-1:0]  cnt_h, cnt_v;
  logic [1:0]        mode_q;
  logic              active, frame_org, frame_end;

  assign active    = (state_q != S_IDLE);
  assign frame_org = active && (cnt_h == '0) && (cnt_v == '0);
  assign frame_end = (cnt_h == H_MAX) && (cnt_v == V_MAX);

  // RGB565 colour of each of the eight bars, left to right.
  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = 16'hFFFF;
      3'd1:    bar_color = 16'hFFE0;
      3'd2:    bar_color = 16'h07FF;
      3'd3:    bar_color = 16'h07E0;
      3'd4:    bar_color = 16'hF81F;
      3'd5:    bar_color = 16'hF800;
      3'd6:    bar_color = 16'h001F;
      default: bar_color = 16'h0000;
    endcase
  endfunction

  // State register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state_q <= S_IDLE;
    else         state_q <= state_nx;
  end

  // Next state: a stop request only takes effect once the last position of a frame has been produced.
  always_comb begin
    state_nx = state_q;
    case (state_q)
      S_IDLE:  if (en) state_nx = S_RUN;
      S_RUN:   if (!en) state_nx = S_STOP;
      S_STOP:  if (en) state_nx = S_RUN;
               else if (frame_end) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Raster counters, parked at the origin while idle.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || !active) begin
      cnt_h <= '0;
      cnt_v <= '0;
    end else if (cnt_h == H_MAX) begin
      cnt_h <= '0;
      cnt_v <= (cnt_v == V_MAX) ? '0 : cnt_v + 1'b1;
    end else begin
      cnt_h <= cnt_h + 1'b1;
    end
  end

  // Pattern mode is captured only at the frame origin so a frame never mixes patterns.
  always_ff @(posedge sys_clk) begin
    if (sys_rst)        mode_q <= 2'd0;
    else if (frame_org) mode_q <= mode;
  end

  logic              hs_d, vs_d, de_d, req_d, in_v;
  logic [CNT_W:0]    req_h;
  logic [CNT_W-1:0]  x_cur, y_cur, px_d, py_d;
  logic [2:0]        bar_idx;
  logic [DATA_W-1:0] pat_d, rgb_d;

  // Output decode: next value of every registered output from the current counter position.
  always_comb begin
    in_v  = (cnt_v >= VA_BEG) && (cnt_v < VA_END);
    de_d  = active && in_v && (cnt_h >= HA_BEG) && (cnt_h < HA_END);
    req_h = {1'b0, cnt_h} + RQ_LD;
    req_d = active && in_v && (req_h >= RQ_BEG) && (req_h < RQ_END);
    x_cur = cnt_h - HA_BEG;
    y_cur = cnt_v - VA_BEG;
    px_d  = req_d ? (cnt_h + LEAD - HA_BEG) : '1;
    py_d  = req_d ? y_cur : '1;
    hs_d  = (active && (cnt_h < HS_END)) ? HS_ACT : ~HS_ACT;
    vs_d  = (active && (cnt_v < VS_END)) ? VS_ACT : ~VS_ACT;
    // Columns past 8 full bars fall into the last bar.
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (x_cur >= CNT_W'(k * (H_VALID / 8))) bar_idx = 3'(k);
    end
    case (mode_q)
      2'd0:    pat_d = pix_data;
      2'd1:    pat_d = DATA_W'(bar_color(bar_idx));
      2'd2:    pat_d = (x_cur[5] ^ y_cur[5]) ? DATA_W'(16'hFFFF) : '0;
      default: pat_d = '0;
    endcase
    rgb_d = de_d ? pat_d : '0;
  end

  // Output register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pix_req     <= 1'b0;
      pix_x       <= '1;
      pix_y       <= '1;
      hsync       <= ~HS_ACT;
      vsync       <= ~VS_ACT;
      tft_de      <= 1'b0;
      tft_rgb     <= '0;
      frame_start <= 1'b0;
      running     <= 1'b0;
    end else begin
      pix_req     <= req_d;
      pix_x       <= px_d;
      pix_y       <= py_d;
      hsync       <= hs_d;
      vsync       <= vs_d;
      tft_de      <= de_d;
      tft_rgb     <= rgb_d;
      frame_start <= frame_org;
      running     <= active;
    end
  end

endmodule

// File: tb/tb_tft_timing_gen.sv
// Bench for tft_timing_gen on a small 74x10 raster (740 clocks per frame), REQ_LEAD=2,
// hsync active-low, vsync active-high, synchronous-RAM source returning {y,x}.
module tb_tft_timing_gen;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        en      = 1'b0;
  logic [1:0]  mode    = 2'd0;
  logic [15:0] pix_data = '0;
  logic        pix_req, hsync, vsync, tft_de, frame_start, running;
  logic [7:0]  pix_x, pix_y;
  logic [15:0] tft_rgb;

  always #5 sys_clk = ~sys_clk;

  tft_timing_gen #(
    .H_SYNC(4), .H_BACK(3), .H_VALID(64), .H_FRONT(3),
    .V_SYNC(2), .V_BACK(2), .V_VALID(4), .V_FRONT(2),
    .CNT_W(8), .DATA_W(16), .REQ_LEAD(2), .HS_POL(0), .VS_POL(1)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .en(en), .mode(mode), .pix_data(pix_data),
    .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y), .hsync(hsync), .vsync(vsync),
    .tft_de(tft_de), .tft_rgb(tft_rgb), .frame_start(frame_start), .running(running)
  );

  // Synchronous RAM with one clock of read latency (REQ_LEAD-1).
  always @(posedge sys_clk) pix_data <= {pix_y, pix_x};

  typedef struct packed {
    logic hs, vs, de, req;
    logic [7:0] px, py;
    logic [15:0] rgb;
    logic fs, run;
  } obs_t;

  typedef struct {
    int         cyc;
    logic       en_n;
    logic [1:0] mode_n;
    obs_t       exp;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  task automatic add(input int c, input logic e, input logic [1:0] m,
                     input logic hs, input logic vs, input logic de, input logic req,
                     input logic [7:0] px, input logic [7:0] py, input logic [15:0] rgb,
                     input logic fs, input logic run);
    vec_t v;
    v.cyc = c; v.en_n = e; v.mode_n = m;
    v.exp = '{hs: hs, vs: vs, de: de, req: req, px: px, py: py, rgb: rgb, fs: fs, run: run};
    tbl.push_back(v);
  endtask

  task automatic check_obs(input string name, input obs_t exp);
    obs_t act;
    act = '{hs: hsync, vs: vsync, de: tft_de, req: pix_req, px: pix_x, py: pix_y,
            rgb: tft_rgb, fs: frame_start, run: running};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got hs=%b vs=%b de=%b req=%b x=%h y=%h rgb=%h fs=%b run=%b | want hs=%b vs=%b de=%b req=%b x=%h y=%h rgb=%h fs=%b run=%b",
               name, act.hs, act.vs, act.de, act.req, act.px, act.py, act.rgb, act.fs, act.run,
               exp.hs, exp.vs, exp.de, exp.req, exp.px, exp.py, exp.rgb, exp.fs, exp.run);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  obs_t idle_obs;
  int   cur;
  int   n;
  bit   found;

  initial begin
    idle_obs = '{hs: 1'b1, vs: 1'b0, de: 1'b0, req: 1'b0, px: 8'hFF, py: 8'hFF,
                 rgb: 16'h0, fs: 1'b0, run: 1'b0};

    // cyc = clocks since en=1 was applied; outputs at cyc k show position k-2.
    //   cyc   en mode  hs vs de rq  px     py     rgb        fs run
    add(2,    1, 0,    0, 1, 0, 0, 8'hFF, 8'hFF, 16'h0000, 1, 1);
    add(3,    1, 0,    0, 1, 0, 0, 8'hFF, 8'hFF, 16'h0000, 0, 1);
    add(5,    1, 0,    0, 1, 0, 0, 8'hFF, 8'hFF, 16'h0000, 0, 1);
    add(6,    1, 0,    1, 1, 0, 0, 8'hFF, 8'hFF, 16'h0000, 0, 1);
    add(149,  1, 0,    1, 1, 0, 0, 8'hFF, 8'hFF, 16'h0000, 0, 1);
    add(150,  1, 0,    0, 0, 0, 0, 8'hFF, 8'hFF, 16'h0000, 0, 1);
    add(302,  1, 0,    1, 0, 0, 0, 8'hFF, 8'hFF, 16'h0000, 0, 1);
    add(303,  1, 0,    1, 0, 0, 1, 8'h00, 8'h00, 16'h0000, 0, 1);
    add(305,  1, 0,    1, 0, 1, 1, 8'h02, 8'h00, 16'h0000, 0, 1);
    add(306,  1, 0,    1, 0, 1, 1, 8'h03, 8'h00, 16'h0001, 0, 1);
    add(366,  1, 0,    1, 0, 1, 1, 8'h3F, 8'h00, 16'h003D, 0, 1);
    add(367,  1, 0,    1, 0, 1, 0, 8'hFF, 8'hFF, 16'h003E, 0, 1);
    add(368,  1, 0,    1, 0, 1, 0, 8'hFF, 8'hFF, 16'h003F, 0, 1);
    add(369,  1, 0,    1, 0, 0, 0, 8'hFF, 8'hFF, 16'h0000, 0, 1);
    add(400,  1, 1,    1, 0, 1, 1, 8'h17, 8'h01, 16'h0115, 0, 1);  // mode->bars mid-frame
    add(530,  1, 1,    1, 0, 1, 1, 8'h05, 8'h03, 16'h0303, 0, 1);  // still pass-through
    add(604,  1, 1,    1, 0, 0, 0, 8'hFF, 8'hFF, 16'h0000, 0, 1);
    add(741,  1, 1,    1, 0, 0, 0, 8'hFF, 8'hFF, 16'h0000, 0, 1);
    add(742,  1, 1,    0, 1, 0, 0, 8'hFF, 8'hFF, 16'h0000, 1, 1);
    add(1045, 1, 1,    1, 0, 1, 1, 8'h02, 8'h00, 16'hFFFF, 0, 1);
    add(1052, 1, 1,    1, 0, 1, 1, 8'h09, 8'h00, 16'hFFFF, 0, 1);
    add(1053, 1, 1,    1, 0, 1, 1, 8'h0A, 8'h00, 16'hFFE0, 0, 1);
    add(1065, 1, 1,    1, 0, 1, 1, 8'h16, 8'h00, 16'h07FF, 0, 1);
    add(1077, 1, 1,    1, 0, 1, 1, 8'h22, 8'h00, 16'hF81F, 0, 1);
    add(1092, 1, 1,    1, 0, 1, 1, 8'h31, 8'h00, 16'hF800, 0, 1);
    add(1093, 1, 1,    1, 0, 1, 1, 8'h32, 8'h00, 16'h001F, 0, 1);
    add(1200, 1, 2,    1, 0, 1, 1, 8'h09, 8'h02, 16'hFFFF, 0, 1);  // mode->checker mid-frame
    add(1482, 1, 2,    0, 1, 0, 0, 8'hFF, 8'hFF, 16'h0000, 1, 1);
    add(1785, 1, 2,    1, 0, 1, 1, 8'h02, 8'h00, 16'h0000, 0, 1);
    add(1816, 1, 2,    1, 0, 1, 1, 8'h21, 8'h00, 16'h0000, 0, 1);
    add(1817, 1, 2,    1, 0, 1, 1, 8'h22, 8'h00, 16'hFFFF, 0, 1);
    add(1848, 1, 2,    1, 0, 1, 0, 8'hFF, 8'hFF, 16'hFFFF, 0, 1);
    add(1850, 0, 3,    1, 0, 0, 0, 8'hFF, 8'hFF, 16'h0000, 0, 1);  // stop request mid-frame
    add(1900, 0, 3,    1, 0, 1, 1, 8'h2B, 8'h01, 16'hFFFF, 0, 1);
    add(2221, 0, 3,    1, 0, 0, 0, 8'hFF, 8'hFF, 16'h0000, 0, 1);  // last position of frame
    add(2222, 0, 3,    1, 0, 0, 0, 8'hFF, 8'hFF, 16'h0000, 0, 0);
    add(2230, 0, 3,    1, 0, 0, 0, 8'hFF, 8'hFF, 16'h0000, 0, 0);

    // Reset state, and staying idle with en low.
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check_obs("reset_state", idle_obs);
    sys_rst = 1'b0;
    repeat (3) @(negedge sys_clk);
    check_obs("idle_en_low", idle_obs);

    // Table-driven run.
    en  = 1'b1;
    cur = 0;
    foreach (tbl[i]) begin
      while (cur < tbl[i].cyc) begin
        @(posedge sys_clk);
        cur++;
      end
      @(negedge sys_clk);
      check_obs($sformatf("vec@%0d", tbl[i].cyc), tbl[i].exp);
      en   = tbl[i].en_n;
      mode = tbl[i].mode_n;
    end

    // Restart, drop en mid-frame and re-raise it during STOP_PEND: timing must not glitch.
    mode  = 2'd0;
    en    = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge sys_clk);
      if (frame_start) found = 1'b1;
    end
    check_int("restart_frame_start", int'(found), 1);
    n = 0;
    found = 1'b0;
    while (!found && n < 2000) begin
      @(negedge sys_clk);
      n++;
      if (n == 300) en = 1'b0;
      if (n == 400) check_int("running_in_stop_pend", int'(running), 1);
      if (n == 500) en = 1'b1;
      if (frame_start) found = 1'b1;
    end
    check_int("frame_period_after_rearm", n, 740);

    // Synchronous reset mid-line, then a clean restart with en still high.
    repeat (100) @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check_obs("mid_line_reset", idle_obs);
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);
    check_obs("post_reset_origin",
              '{hs: 1'b0, vs: 1'b1, de: 1'b0, req: 1'b0, px: 8'hFF, py: 8'hFF,
                rgb: 16'h0, fs: 1'b1, run: 1'b1});
    repeat (304) @(negedge sys_clk);
    check_obs("post_reset_pixel1",
              '{hs: 1'b1, vs: 1'b0, de: 1'b1, req: 1'b1, px: 8'h03, py: 8'h00,
                rgb: 16'h0001, fs: 1'b0, run: 1'b1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
